// File: rtl/vga_sync_if.sv
// VGA timing bundle: syncs, visible flag, position and pixel strobes.
// The timing generator drives it as master; downstream stages read it as slave.
interface vga_sync_if;
  logic       VGA_H_SYNC;
  logic       VGA_V_SYNC;
  logic       video_on;
  logic [9:0] line_count;
  logic [9:0] pixel_count;
  logic       pix_tick;
  logic       frame_start;

  modport master (
    output VGA_H_SYNC,
    output VGA_V_SYNC,
    output video_on,
    output line_count,
    output pixel_count,
    output pix_tick,
    output frame_start
  );

  modport slave (
    input VGA_H_SYNC,
    input VGA_V_SYNC,
    input video_on,
    input line_count,
    input pixel_count,
    input pix_tick,
    input frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, H/V counters, registered
// syncs, visible-area flag and pixel/frame strobes.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input logic      iCLK,
  input logic      iRST,
  vga_sync_if.master vga
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 ||
        CLK_DIV < 1) begin : g_bad_cfg
      $error("vga_sync_gen: bad timing params");
    end
  endgenerate

  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX =
    10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX =
    10'(V_TOTAL - 1);

  localparam logic [10:0] H_VIS =
    11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG =
    11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END =
    11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS =
    11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG =
    11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END =
    11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       hcnt;
  logic [9:0]       vcnt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             adv;
  logic             hs_nxt;
  logic             vs_nxt;
  logic             von_nxt;
  logic             org_nxt;

  logic hs_r;
  logic vs_r;
  logic von_r;
  logic tick_r;
  logic fs_r;

  assign adv = (div_cnt == DIV_MAX);

  always_comb begin
    h_nxt = hcnt;
    v_nxt = vcnt;
    if (adv) begin
      if (hcnt == H_MAX) begin
        h_nxt = '0;
        v_nxt = (vcnt == V_MAX) ?
          '0 : vcnt + 10'd1;
      end else begin
        h_nxt = hcnt + 10'd1;
      end
    end
  end

  // Decode from the next position so outputs move with the counters.
  always_comb begin
    hs_nxt  = ({1'b0, h_nxt} >= HS_BEG) &&
              ({1'b0, h_nxt} <  HS_END);
    vs_nxt  = ({1'b0, v_nxt} >= VS_BEG) &&
              ({1'b0, v_nxt} <  VS_END);
    von_nxt = ({1'b0, h_nxt} < H_VIS) &&
              ({1'b0, v_nxt} < V_VIS);
    org_nxt = (h_nxt == 10'd0) &&
              (v_nxt == 10'd0);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      div_cnt <= '0;
      hcnt    <= H_MAX;
      vcnt    <= V_MAX;
      hs_r    <= ~SYNC_POL;
      vs_r    <= ~SYNC_POL;
      von_r   <= 1'b0;
      tick_r  <= 1'b0;
      fs_r    <= 1'b0;
    end else begin
      div_cnt <= adv ?
        '0 : div_cnt + DIV_W'(1);
      hcnt    <= h_nxt;
      vcnt    <= v_nxt;
      hs_r    <= hs_nxt ?
        SYNC_POL : ~SYNC_POL;
      vs_r    <= vs_nxt ?
        SYNC_POL : ~SYNC_POL;
      von_r   <= von_nxt;
      tick_r  <= adv;
      fs_r    <= adv && org_nxt;
    end
  end

  assign vga.VGA_H_SYNC  = hs_r;
  assign vga.VGA_V_SYNC  = vs_r;
  assign vga.video_on    = von_r;
  assign vga.line_count  = hcnt;
  assign vga.pixel_count = vcnt;
  assign vga.pix_tick    = tick_r;
  assign vga.frame_start = fs_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing plus three reduced timings
// checked against an elapsed-cycle arithmetic reference.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] lc;
    logic [9:0] pc;
    logic       tick;
    logic       fs;
  } obs_t;

  typedef struct {
    int ha, hfp, hs, hbp;
    int va, vfp, vs, vbp;
    int div;
    bit pol;
  } cfg_t;

  localparam int SHA = 16, SHFP = 4;
  localparam int SHS = 6, SHBP = 4;
  localparam int SVA = 10, SVFP = 2;
  localparam int SVS = 2, SVBP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k = 0;
  int   checks = 0;
  int   failures = 0;

  cfg_t cfg [4];
  obs_t [3:0] obs;

  vga_sync_if if0 ();
  vga_sync_if if1 ();
  vga_sync_if if2 ();
  vga_sync_if if3 ();

  vga_sync_gen u0 (
    .iCLK(clk), .iRST(rst), .vga(if0)
  );

  vga_sync_gen #(
    .H_ACTIVE(SHA), .H_FP(SHFP),
    .H_SYNC(SHS), .H_BP(SHBP),
    .V_ACTIVE(SVA), .V_FP(SVFP),
    .V_SYNC(SVS), .V_BP(SVBP),
    .CLK_DIV(2), .SYNC_POL(1'b0)
  ) u1 (
    .iCLK(clk), .iRST(rst), .vga(if1)
  );

  vga_sync_gen #(
    .H_ACTIVE(SHA), .H_FP(SHFP),
    .H_SYNC(SHS), .H_BP(SHBP),
    .V_ACTIVE(SVA), .V_FP(SVFP),
    .V_SYNC(SVS), .V_BP(SVBP),
    .CLK_DIV(1), .SYNC_POL(1'b1)
  ) u2 (
    .iCLK(clk), .iRST(rst), .vga(if2)
  );

  vga_sync_gen #(
    .H_ACTIVE(SHA), .H_FP(SHFP),
    .H_SYNC(SHS), .H_BP(SHBP),
    .V_ACTIVE(SVA), .V_FP(SVFP),
    .V_SYNC(SVS), .V_BP(SVBP),
    .CLK_DIV(3), .SYNC_POL(1'b0)
  ) u3 (
    .iCLK(clk), .iRST(rst), .vga(if3)
  );

  assign obs[0] = {if0.VGA_H_SYNC, if0.VGA_V_SYNC,
    if0.video_on, if0.line_count, if0.pixel_count,
    if0.pix_tick, if0.frame_start};
  assign obs[1] = {if1.VGA_H_SYNC, if1.VGA_V_SYNC,
    if1.video_on, if1.line_count, if1.pixel_count,
    if1.pix_tick, if1.frame_start};
  assign obs[2] = {if2.VGA_H_SYNC, if2.VGA_V_SYNC,
    if2.video_on, if2.line_count, if2.pixel_count,
    if2.pix_tick, if2.frame_start};
  assign obs[3] = {if3.VGA_H_SYNC, if3.VGA_V_SYNC,
    if3.video_on, if3.line_count, if3.pixel_count,
    if3.pix_tick, if3.frame_start};

  always #5 clk = ~clk;

  // Edges seen since reset was last released.
  always @(posedge clk or posedge rst)
    if (rst) k <= 0;
    else     k <= k + 1;

  function automatic int htot(cfg_t c);
    return c.ha + c.hfp + c.hs + c.hbp;
  endfunction

  function automatic int vtot(cfg_t c);
    return c.va + c.vfp + c.vs + c.vbp;
  endfunction

  // Position after n edges: advances = n/div, pixel index = advances-1.
  function automatic obs_t model(cfg_t c, int n);
    int ht, vt, a, p, h, v;
    obs_t o;
    ht = htot(c);
    vt = vtot(c);
    if (n < c.div) begin
      o.hs = ~c.pol;
      o.vs = ~c.pol;
      o.von = 1'b0;
      o.lc = 10'(ht - 1);
      o.pc = 10'(vt - 1);
      o.tick = 1'b0;
      o.fs = 1'b0;
      return o;
    end
    a = n / c.div;
    p = (a - 1) % (ht * vt);
    h = p % ht;
    v = p / ht;
    o.lc = 10'(h);
    o.pc = 10'(v);
    o.tick = ((n % c.div) == 0);
    o.fs = o.tick && (p == 0);
    o.von = (h < c.ha) && (v < c.va);
    o.hs = (h >= c.ha + c.hfp &&
            h < c.ha + c.hfp + c.hs) ?
           c.pol : ~c.pol;
    o.vs = (v >= c.va + c.vfp &&
            v < c.va + c.vfp + c.vs) ?
           c.pol : ~c.pol;
    return o;
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    e = '{1'b1, 1'b1, 1'b0, 10'd799, 10'd524,
          1'b0, 1'b0};
    checks++;
    if (obs[0] !== e) begin
      failures++;
      $display("FAIL reset_hold_def got=%h exp=%h",
        obs[0], e);
    end
    e = '{1'b0, 1'b0, 1'b0, 10'd29, 10'd16,
          1'b0, 1'b0};
    checks++;
    if (obs[2] !== e) begin
      failures++;
      $display("FAIL reset_hold_pol1 got=%h exp=%h",
        obs[2], e);
    end
    rst = 1'b0;
    @(negedge clk);
    e = '{1'b1, 1'b1, 1'b0, 10'd799, 10'd524,
          1'b0, 1'b0};
    checks++;
    if (obs[0] !== e) begin
      failures++;
      $display("FAIL rel_edge1 got=%h exp=%h",
        obs[0], e);
    end
    e = '{1'b0, 1'b0, 1'b1, 10'd0, 10'd0,
          1'b1, 1'b1};
    checks++;
    if (obs[2] !== e) begin
      failures++;
      $display("FAIL rel_edge1_div1 got=%h exp=%h",
        obs[2], e);
    end
    @(negedge clk);
    e = '{1'b1, 1'b1, 1'b1, 10'd0, 10'd0,
          1'b1, 1'b1};
    checks++;
    if (obs[0] !== e) begin
      failures++;
      $display("FAIL rel_edge2 got=%h exp=%h",
        obs[0], e);
    end
    @(negedge clk);
    e = '{1'b1, 1'b1, 1'b1, 10'd0, 10'd0,
          1'b0, 1'b0};
    checks++;
    if (obs[0] !== e) begin
      failures++;
      $display("FAIL rel_edge3 got=%h exp=%h",
        obs[0], e);
    end
    @(negedge clk);
    e = '{1'b1, 1'b1, 1'b1, 10'd1, 10'd0,
          1'b1, 1'b0};
    checks++;
    if (obs[0] !== e) begin
      failures++;
      $display("FAIL rel_edge4 got=%h exp=%h",
        obs[0], e);
    end
  endtask

  task automatic test_line_timing();
    int rowcyc, hslow, vonc, first_lc, runs;
    bit done;
    obs_t prev;
    rowcyc = 0; hslow = 0; vonc = 0;
    first_lc = -1; runs = 0; done = 0;
    prev = obs[0];
    for (int c = 0; c < 8000 && !done; c++) begin
      @(negedge clk);
      if (prev.lc == 10'd799 && obs[0].lc == 10'd0) begin
        checks++;
        if (obs[0].pc !== prev.pc + 10'd1) begin
          failures++;
          $display("FAIL line_wrap got=%0d exp=%0d",
            obs[0].pc, prev.pc + 10'd1);
        end
      end
      if (obs[0].pc == 10'd1) begin
        rowcyc++;
        if (obs[0].von) vonc++;
        if (!obs[0].hs) begin
          hslow++;
          if (prev.hs) begin
            runs++;
            if (first_lc < 0) first_lc = int'(obs[0].lc);
          end
        end
      end
      if (obs[0].pc == 10'd2) done = 1;
      prev = obs[0];
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL line_timeout got=%0d exp=1", done);
    end
    checks++;
    if (rowcyc != 1600) begin
      failures++;
      $display("FAIL row_cycles got=%0d exp=1600", rowcyc);
    end
    checks++;
    if (hslow != 192 || runs != 1) begin
      failures++;
      $display("FAIL hsync_low got=%0d/%0d exp=192/1",
        hslow, runs);
    end
    checks++;
    if (first_lc != 656) begin
      failures++;
      $display("FAIL hsync_start got=%0d exp=656", first_lc);
    end
    checks++;
    if (vonc != 1280) begin
      failures++;
      $display("FAIL row_video got=%0d exp=1280", vonc);
    end
  endtask

  task automatic test_frame_timing();
    int last_fs, vlow, vonc, frames;
    int exp_int, exp_vlow, exp_von, vs_row;
    bit prev_vs;
    obs_t e;
    exp_int  = htot(cfg[1]) * vtot(cfg[1]) * cfg[1].div;
    exp_vlow = htot(cfg[1]) * cfg[1].vs * cfg[1].div;
    exp_von  = cfg[1].ha * cfg[1].va * cfg[1].div;
    vs_row   = cfg[1].va + cfg[1].vfp;
    last_fs = -1; vlow = 0; vonc = 0; frames = 0;
    prev_vs = 1'b1;
    pulse_reset();
    for (int c = 0; c < 3 * exp_int + 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        e = model(cfg[i], k);
        checks++;
        if (obs[i] !== e) begin
          failures++;
          $display("FAIL frame_model inst=%0d k=%0d got=%h exp=%h",
            i, k, obs[i], e);
        end
      end
      if (obs[1].fs) begin
        if (last_fs >= 0) begin
          frames++;
          checks++;
          if (k - last_fs != exp_int || vlow != exp_vlow ||
              vonc != exp_von) begin
            failures++;
            $display("FAIL frame_meas got=%0d/%0d/%0d exp=%0d/%0d/%0d",
              k - last_fs, vlow, vonc,
              exp_int, exp_vlow, exp_von);
          end
        end
        last_fs = k; vlow = 0; vonc = 0;
      end
      if (!obs[1].vs) vlow++;
      if (obs[1].von) vonc++;
      if (prev_vs && !obs[1].vs) begin
        checks++;
        if (obs[1].lc !== 10'd0 ||
            obs[1].pc !== 10'(vs_row)) begin
          failures++;
          $display("FAIL vsync_edge got=%0d,%0d exp=0,%0d",
            obs[1].lc, obs[1].pc, vs_row);
        end
      end
      prev_vs = obs[1].vs;
    end
    checks++;
    if (frames != 3) begin
      failures++;
      $display("FAIL frame_count got=%0d exp=3", frames);
    end
  endtask

  task automatic test_clkdiv1_pol();
    int last_fs, hsh, vsh, rowc, frames;
    int exp_int, exp_hsh, exp_vsh, ht;
    ht = htot(cfg[2]);
    exp_int = ht * vtot(cfg[2]);
    exp_hsh = cfg[2].hs * vtot(cfg[2]);
    exp_vsh = cfg[2].vs * ht;
    last_fs = -1; hsh = 0; vsh = 0;
    rowc = 0; frames = 0;
    pulse_reset();
    for (int c = 0; c < 2 * exp_int + 5; c++) begin
      @(negedge clk);
      checks++;
      if (obs[2].tick !== 1'b1) begin
        failures++;
        $display("FAIL div1_tick k=%0d got=%b exp=1",
          k, obs[2].tick);
      end
      if (obs[2].fs) begin
        if (last_fs >= 0) begin
          frames++;
          checks++;
          if (k - last_fs != exp_int || hsh != exp_hsh ||
              vsh != exp_vsh || rowc != ht) begin
            failures++;
            $display("FAIL pol1_meas got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
              k - last_fs, hsh, vsh, rowc,
              exp_int, exp_hsh, exp_vsh, ht);
          end
        end
        last_fs = k; hsh = 0; vsh = 0; rowc = 0;
      end
      if (obs[2].hs) hsh++;
      if (obs[2].vs) vsh++;
      if (obs[2].pc == 10'd3) rowc++;
    end
    checks++;
    if (frames != 2) begin
      failures++;
      $display("FAIL div1_frames got=%0d exp=2", frames);
    end
  endtask

  task automatic test_async_reset();
    int n;
    obs_t e;
    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(40, 1400));
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          e = model(cfg[i], k);
          checks++;
          if (obs[i] !== e) begin
            failures++;
            $display("FAIL pre_rst inst=%0d k=%0d got=%h exp=%h",
              i, k, obs[i], e);
          end
        end
      end
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
        e = model(cfg[i], 0);
        checks++;
        if (obs[i] !== e) begin
          failures++;
          $display("FAIL async_rst inst=%0d got=%h exp=%h",
            i, obs[i], e);
        end
      end
      repeat (int'($urandom_range(1, 3))) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          e = model(cfg[i], k);
          checks++;
          if (obs[i] !== e) begin
            failures++;
            $display("FAIL restart inst=%0d k=%0d got=%h exp=%h",
              i, k, obs[i], e);
          end
        end
      end
    end
  endtask

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0};
    cfg[1] = '{SHA, SHFP, SHS, SHBP,
               SVA, SVFP, SVS, SVBP, 2, 1'b0};
    cfg[2] = '{SHA, SHFP, SHS, SHBP,
               SVA, SVFP, SVS, SVBP, 1, 1'b1};
    cfg[3] = '{SHA, SHFP, SHS, SHBP,
               SVA, SVFP, SVS, SVBP, 3, 1'b0};
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_clkdiv1_pol();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
